// File: rtl/sprite_arb_pkg.sv
// Shared types and widths for the sprite RAM fetch arbiter.
// Owner tags are OWNER_W bits wide, so up to 16 requesters are supported.
package sprite_arb_pkg;

  localparam int INDEX_W = 8;
  localparam int LINE_W  = 4;
  localparam int DATA_W  = 16;
  localparam int LEN_W   = 4;
  localparam int OWNER_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic               valid;
    logic [OWNER_W-1:0] owner;
    logic               last;
  } tag_t;

  // Sprite lines wrap within the 16-line sprite.
  function automatic logic [LINE_W-1:0] next_line(input logic [LINE_W-1:0] line);
    return line + 1'b1;
  endfunction

endpackage

// File: rtl/sprite_fetch_arbiter_if.sv
// Requester, sprite RAM and response signals of the fetch arbiter.
// master = requesters/RAM side, slave = arbiter side.
interface sprite_fetch_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import sprite_arb_pkg::*;

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ-1:0][INDEX_W-1:0] req_index;
  logic [NUM_REQ-1:0][LINE_W-1:0]  req_line;
  logic [NUM_REQ-1:0][LEN_W-1:0]   req_len;
  logic                            ram_hold;
  logic [INDEX_W-1:0]              ram_index;
  logic [LINE_W-1:0]               ram_line;
  logic [DATA_W-1:0]               ram_data;
  logic [NUM_REQ-1:0]              rsp_valid;
  logic [DATA_W-1:0]               rsp_data;
  logic                            rsp_last;

  modport master (
    output req_valid, req_index, req_line, req_len, ram_hold, ram_data,
    input  req_ready, ram_index, ram_line, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_index, req_line, req_len, ram_hold, ram_data,
    output req_ready, ram_index, ram_line, rsp_valid, rsp_data, rsp_last
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant; search starts at the requester after the last accepted one.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] cand;
  logic             found;
  int               pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    pos       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = PTR_W'(pos);
      if (enable && !found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

  // Pointer only moves on an accepted grant, so a lone requester keeps winning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Shares the sprite RAM read port between NUM_REQ burst requesters and routes
// each returned line back to its owner, in issue order, RD_LAT+1 cycles after issue.
module sprite_fetch_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int RD_LAT  = 1
) (
  input logic                     CLK_100,
  input logic                     RESET_N,
  sprite_fetch_arbiter_if.slave   bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant;
  logic [PTR_W-1:0]     grant_idx;
  logic                 arb_en, accept, issue, last_beat;
  logic [INDEX_W-1:0]   index_q;
  logic [LINE_W-1:0]    line_q;
  logic [LEN_W-1:0]     len_q, beat_q;
  logic [OWNER_W-1:0]   owner_q;
  tag_t                 issue_tag;
  tag_t                 tag_p [RD_LAT+1];
  logic [DATA_W-1:0]    rsp_data_p;

  // Grant only from IDLE, never while the RAM is being written or in reset.
  assign arb_en = RESET_N && (state_q == IDLE) && !bus.ram_hold;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .clk       (CLK_100),
    .rst_n     (RESET_N),
    .req       (bus.req_valid),
    .enable    (arb_en),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept        = |grant;
  assign bus.req_ready = grant;
  assign issue         = (state_q == BURST) && !bus.ram_hold;
  assign last_beat     = issue && (beat_q == len_q);

  always_ff @(posedge CLK_100 or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = BURST;
      BURST:   if (last_beat) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Burst context: latched at handshake, address advances once per issued beat.
  always_ff @(posedge CLK_100 or negedge RESET_N) begin
    if (!RESET_N) begin
      index_q <= '0;
      line_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      owner_q <= '0;
    end else if (accept) begin
      index_q <= bus.req_index[grant_idx];
      line_q  <= bus.req_line[grant_idx];
      len_q   <= bus.req_len[grant_idx];
      beat_q  <= '0;
      owner_q <= OWNER_W'(grant_idx);
    end else if (issue) begin
      beat_q  <= beat_q + 1'b1;
      line_q  <= next_line(line_q);
    end
  end

  assign bus.ram_index = index_q;
  assign bus.ram_line  = line_q;

  // Tag pipeline stage boundary: one entry per issued beat, aligned with the RAM latency.
  assign issue_tag = '{valid: issue, owner: owner_q, last: last_beat};

  always_ff @(posedge CLK_100 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k <= RD_LAT; k++) tag_p[k] <= '0;
      rsp_data_p <= '0;
    end else begin
      tag_p[0] <= issue_tag;
      for (int k = 1; k <= RD_LAT; k++) tag_p[k] <= tag_p[k-1];
      rsp_data_p <= bus.ram_data;
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid[i] = tag_p[RD_LAT].valid && (tag_p[RD_LAT].owner == OWNER_W'(i));
    end
  end

  assign bus.rsp_last = tag_p[RD_LAT].valid && tag_p[RD_LAT].last;
  assign bus.rsp_data = rsp_data_p;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Bench for sprite_fetch_arbiter: transaction-level model checked every cycle,
// plus directed bursts with literal expected lines, grants and data.
module tb_sprite_fetch_arbiter;
  import sprite_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int RD_LAT  = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sprite_fetch_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  sprite_fetch_arbiter #(
    .NUM_REQ (NUM_REQ),
    .RD_LAT  (RD_LAT)
  ) dut (
    .CLK_100 (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RAM contents: word = {index, 4'hA, line}; one-cycle read latency.
  function automatic logic [15:0] word(input logic [7:0] idx, input logic [3:0] ln);
    return {idx, 4'hA, ln};
  endfunction

  always @(posedge clk) bus.ram_data <= word(bus.ram_index, bus.ram_line);

  typedef struct {
    int          due;
    int          owner;
    logic [15:0] data;
    bit          last;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [15:0] log_data[$];
  int          log_owner[$];
  bit          log_last[$];
  int          grant_log[$];
  int          pulse_cnt;
  logic [15:0] exp_words [8];

  bit          m_busy = 0;
  int          m_ptr = 0, m_owner = 0, m_left = 0, cyc = 0;
  logic [7:0]  m_index = '0;
  logic [3:0]  m_line = '0;

  // Model: a burst is a list of addresses index:line, line+1, ... issued one per
  // non-hold cycle; each address comes back as data RD_LAT+1 cycles later.
  always @(negedge clk) begin : compare
    logic [NUM_REQ-1:0] exp_rdy, exp_vld;
    int   g, r;
    rsp_t e;
    cyc++;
    if (!rst_n) begin
      m_busy = 0;
      m_ptr  = 0;
      exp_q.delete();
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_data",  32'(bus.rsp_data),  0);
      chk("rst_rsp_last",  32'(bus.rsp_last),  0);
      chk("rst_ram_index", 32'(bus.ram_index), 0);
      chk("rst_ram_line",  32'(bus.ram_line),  0);
    end else begin
      exp_rdy = '0;
      g = -1;
      if (!m_busy && !bus.ram_hold) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          r = (m_ptr + k) % NUM_REQ;
          if (g < 0 && bus.req_valid[r]) begin
            g = r;
            exp_rdy[r] = 1'b1;
          end
        end
      end
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      if (m_busy) begin
        chk("ram_index", 32'(bus.ram_index), 32'(m_index));
        chk("ram_line",  32'(bus.ram_line),  32'(m_line));
      end
      exp_vld = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        exp_vld[e.owner] = 1'b1;
        chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        chk("rsp_last", 32'(bus.rsp_last), 32'(e.last));
      end else begin
        chk("rsp_last_idle", 32'(bus.rsp_last), 0);
      end
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_vld));

      if (|bus.rsp_valid) begin
        pulse_cnt++;
        log_data.push_back(bus.rsp_data);
        log_last.push_back(bus.rsp_last);
        for (int k = 0; k < NUM_REQ; k++) if (bus.rsp_valid[k]) log_owner.push_back(k);
      end
      for (int k = 0; k < NUM_REQ; k++)
        if (bus.req_valid[k] && bus.req_ready[k]) grant_log.push_back(k);

      if (m_busy) begin
        if (!bus.ram_hold) begin
          e.due   = cyc + RD_LAT + 1;
          e.owner = m_owner;
          e.data  = word(m_index, m_line);
          e.last  = (m_left == 1);
          exp_q.push_back(e);
          m_line = m_line + 4'd1;
          m_left--;
          if (m_left == 0) m_busy = 0;
        end
      end else if (g >= 0) begin
        m_busy  = 1;
        m_owner = g;
        m_index = bus.req_index[g];
        m_line  = bus.req_line[g];
        m_left  = int'(bus.req_len[g]) + 1;
        m_ptr   = (g + 1) % NUM_REQ;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic clear_logs();
    log_data.delete();
    log_owner.delete();
    log_last.delete();
    grant_log.delete();
    pulse_cnt = 0;
  endtask

  // Returns at the start of the cycle in which the first burst address is presented.
  task automatic request(input int r, input logic [7:0] idx, input logic [3:0] ln,
                         input logic [3:0] len);
    bit done = 0;
    bus.req_index[r] = idx;
    bus.req_line[r]  = ln;
    bus.req_len[r]   = len;
    bus.req_valid[r] = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.req_ready[r]) done = 1;
      @(posedge clk);
      #1;
    end
    bus.req_valid[r] = 1'b0;
    chk("handshake", 32'(done), 1);
  endtask

  task automatic check_burst(input string tag, input int owner, input int n);
    chk({tag, "_count"}, log_data.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < log_data.size()) begin
        chk({tag, "_data"},  32'(log_data[i]), 32'(exp_words[i]));
        chk({tag, "_owner"}, log_owner[i], owner);
        chk({tag, "_last"},  32'(log_last[i]), 32'(i == n - 1));
      end
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_index = '0;
    bus.req_line  = '0;
    bus.req_len   = '0;
    bus.ram_hold  = 1'b0;
    #1 rst_n = 1'b0;
    step(3);
    chk("reset_ram_line",  32'(bus.ram_line),  0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    rst_n = 1'b1;
    step(2);

    // Single burst on requester 0.
    clear_logs();
    request(0, 8'h80, 4'd0, 4'd3);
    chk("t1_line0", 32'(bus.ram_line), 0);
    chk("t1_index", 32'(bus.ram_index), 32'h80);
    step(1); chk("t1_line1", 32'(bus.ram_line), 1);
    step(1); chk("t1_line2", 32'(bus.ram_line), 2);
    step(1); chk("t1_line3", 32'(bus.ram_line), 3);
    step(8);
    exp_words = '{16'h80A0, 16'h80A1, 16'h80A2, 16'h80A3, 16'h0, 16'h0, 16'h0, 16'h0};
    check_burst("t1", 0, 4);

    // Line wrap on requester 1.
    clear_logs();
    request(1, 8'h01, 4'd14, 4'd3);
    chk("t2_line14", 32'(bus.ram_line), 14);
    step(1); chk("t2_line15", 32'(bus.ram_line), 15);
    step(1); chk("t2_line0",  32'(bus.ram_line), 0);
    step(1); chk("t2_line1",  32'(bus.ram_line), 1);
    step(8);
    exp_words = '{16'h01AE, 16'h01AF, 16'h01A0, 16'h01A1, 16'h0, 16'h0, 16'h0, 16'h0};
    check_burst("t2", 1, 4);

    // Contention with single-beat bursts after a fresh reset.
    do_reset();
    clear_logs();
    bus.req_index[0] = 8'h10; bus.req_line[0] = 4'd0; bus.req_len[0] = 4'd0;
    bus.req_index[1] = 8'h20; bus.req_line[1] = 4'd0; bus.req_len[1] = 4'd0;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 40 && grant_log.size() < 4; k++) step(1);
    bus.req_valid = 2'b00;
    step(6);
    chk("t3_grants", grant_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) chk("t3_grant_order", grant_log[i], i % 2);

    // ram_hold for two cycles in the middle of an 8-beat burst.
    clear_logs();
    request(0, 8'h22, 4'd0, 4'd7);
    step(2);
    bus.ram_hold = 1'b1;
    chk("t4_hold_line_a", 32'(bus.ram_line), 2);
    step(1);
    chk("t4_hold_line_b", 32'(bus.ram_line), 2);
    step(1);
    bus.ram_hold = 1'b0;
    chk("t4_resume_line", 32'(bus.ram_line), 2);
    step(1);
    chk("t4_next_line", 32'(bus.ram_line), 3);
    step(15);
    exp_words = '{16'h22A0, 16'h22A1, 16'h22A2, 16'h22A3,
                  16'h22A4, 16'h22A5, 16'h22A6, 16'h22A7};
    check_burst("t4", 0, 8);

    // ram_hold in IDLE blocks the grant until it falls.
    clear_logs();
    bus.ram_hold = 1'b1;
    bus.req_index[0] = 8'h33; bus.req_line[0] = 4'd5; bus.req_len[0] = 4'd0;
    bus.req_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_ready_in_hold", 32'(bus.req_ready), 0);
      @(posedge clk);
      #1;
    end
    bus.ram_hold = 1'b0;
    @(negedge clk);
    chk("t5_ready_on_release", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    step(6);
    exp_words = '{16'h33A5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    check_burst("t5", 0, 1);

    // Reset during the third beat of a 16-beat burst.
    clear_logs();
    request(0, 8'h44, 4'd0, 4'd15);
    step(2);
    chk("t6_beat3_line", 32'(bus.ram_line), 2);
    rst_n = 1'b0;
    #1;
    chk("t6_ram_index",  32'(bus.ram_index), 0);
    chk("t6_ram_line",   32'(bus.ram_line),  0);
    chk("t6_rsp_valid",  32'(bus.rsp_valid), 0);
    chk("t6_rsp_data",   32'(bus.rsp_data),  0);
    chk("t6_rsp_last",   32'(bus.rsp_last),  0);
    chk("t6_req_ready",  32'(bus.req_ready), 0);
    step(2);
    rst_n = 1'b1;
    pulse_cnt = 0;
    step(12);
    chk("t6_no_rsp_after_reset", pulse_cnt, 0);

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sprite_fetch_arbiter.md
SPRITE_FETCH_ARBITER -- requirements
Module: sprite_fetch_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing the sprite_ram read port.
REQ-002 Parameter RD_LAT, default 1, cycles from ram_index/ram_line change to valid ram_data.
REQ-003 CLK_100  in  1  sole clock; all state on its rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  NUM_REQ  per-requester burst request.
REQ-006 req_ready  out  NUM_REQ  per-requester grant; handshake when valid and ready are both high.
REQ-007 req_index  in  NUM_REQ x 8  sprite index per requester.
REQ-008 req_line  in  NUM_REQ x 4  first line per requester.
REQ-009 req_len  in  NUM_REQ x 4  burst length minus one (1..16 lines).
REQ-010 ram_hold  in  1  Avalon write to sprite RAM in progress; blocks issue.
REQ-011 ram_index  out  8  drives sprite_ram get_index.
REQ-012 ram_line  out  4  drives sprite_ram get_line.
REQ-013 ram_data  in  16  from sprite_ram get_data.
REQ-014 rsp_valid  out  NUM_REQ  one-cycle pulse per returned line, to owning requester only; no backpressure.
REQ-015 rsp_data  out  16  returned line, registered.
REQ-016 rsp_last  out  1  high with the final beat of a burst.

Function
REQ-017 FSM states: IDLE, BURST; one burst owns the port at a time; no preemption.
REQ-018 IDLE: if ram_hold low, req_ready SHALL go high (combinationally) for exactly one requester with req_valid high, chosen round-robin starting after the last granted requester.
REQ-019 req_ready SHALL be low for all requesters in BURST, during ram_hold, and in reset.
REQ-020 On handshake at cycle t: latch index/line/len, owner; enter BURST; ram_index/ram_line take first address at t+1.
REQ-021 BURST: one beat issued per cycle with ram_hold low; ram_line increments by 1 per issued beat, modulo 16 (15 wraps to 0); ram_index constant.
REQ-022 ram_hold high in BURST: no beat issued, ram_index/ram_line held; issue resumes the cycle after ram_hold falls.
REQ-023 After beat number req_len+1 issues, FSM SHALL return to IDLE on the next edge; one bubble cycle between bursts.
REQ-024 Each issued beat enters an RD_LAT+1 deep tag pipeline (valid, owner, last); rsp_data = ram_data registered; rsp_valid[owner] asserted RD_LAT+1 cycles after the beat's address appears.
REQ-025 Response order SHALL equal issue order; no beat dropped or duplicated, including across ram_hold.
REQ-026 Round-robin pointer updates only on handshake; a lone requester may be granted back-to-back.
REQ-027 Requester SHALL hold req_* stable while req_valid high and req_ready low; arbiter samples them only at handshake.

Reset
REQ-028 RESET_N low SHALL asynchronously force: FSM IDLE, req_ready 0, rsp_valid 0, rsp_data 0, rsp_last 0, ram_index 0, ram_line 0, tag pipeline empty, round-robin pointer to requester 0.
REQ-029 Reset mid-burst SHALL discard all in-flight beats; no rsp_valid after RESET_N rises until a new handshake.

Structure
REQ-030 Package sprite_arb_pkg SHALL hold the FSM state enum, tag struct (valid, owner, last), and width constants (INDEX_W=8, LINE_W=4, DATA_W=16).
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arbiter (req vector, enable, grant one-hot, pointer update on accept).

Verification
REQ-032 Single burst: req0 index 8'h80, line 0, len 3 -> ram_line 0,1,2,3 on consecutive cycles; four rsp_valid[0] pulses, data matches RAM words 0..3, rsp_last on 4th; rsp_valid[1] never high.
REQ-033 Wrap: req1 index 8'h01, line 14, len 3 -> ram_line 14,15,0,1; rsp_last on the beat for line 1.
REQ-034 Contention: req0 and req1 both valid continuously, len 0 -> grants alternate 0,1,0,1 starting with 0 after reset.
REQ-035 Hold: ram_hold high for 2 cycles mid-burst (len 7) -> ram_line frozen 2 cycles, total 8 responses in order, none duplicated.
REQ-036 Reset: RESET_N low during beat 3 of a len-15 burst -> all outputs 0 immediately; zero rsp_valid pulses after release while req_valid stays low.
REQ-037 Hold in IDLE: ram_hold high with req0 valid -> req_ready stays 0; grant the cycle ram_hold falls.
